// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA/loader port.
// CPU has fixed priority; a saturating starvation counter forces a DMA grant after STARVE_LIMIT denials.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              dma_err,

  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_ALUresult,
  output logic [31:0]       mem_MemWriteData,
  input  logic [31:0]       mem_MemReadData
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic        cpu_err_q, cpu_err_d;
  logic        dma_err_q, dma_err_d;

  logic dma_pri;
  logic cpu_misal;
  logic dma_misal;
  logic cpu_load_ok;
  logic dma_load_ok;

  assign dma_pri   = (starve_cnt_q == LIMIT);
  assign cpu_misal = |cpu_addr[1:0];
  assign dma_misal = |dma_addr[1:0];

  // Grants are held off during reset so the memory sees no access then.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst_n) begin
      if (dma_req && dma_pri) begin
        dma_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // A misaligned winner still drives the address, but both strobes stay low.
  always_comb begin
    mem_MemRead      = 1'b0;
    mem_MemWrite     = 1'b0;
    mem_ALUresult    = '0;
    mem_MemWriteData = '0;
    if (cpu_gnt) begin
      mem_ALUresult    = cpu_addr;
      mem_MemWriteData = cpu_wdata;
      mem_MemRead      = ~cpu_we & ~cpu_misal;
      mem_MemWrite     =  cpu_we & ~cpu_misal;
    end else if (dma_gnt) begin
      mem_ALUresult    = dma_addr;
      mem_MemWriteData = dma_wdata;
      mem_MemRead      = ~dma_we & ~dma_misal;
      mem_MemWrite     =  dma_we & ~dma_misal;
    end
  end

  assign cpu_load_ok = cpu_gnt & ~cpu_we & ~cpu_misal;
  assign dma_load_ok = dma_gnt & ~dma_we & ~dma_misal;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || dma_gnt) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end

    cpu_rvalid_d = cpu_load_ok;
    dma_rvalid_d = dma_load_ok;
    cpu_rdata_d  = cpu_load_ok ? mem_MemReadData : cpu_rdata_q;
    dma_rdata_d  = dma_load_ok ? mem_MemReadData : dma_rdata_q;
    cpu_err_d    = cpu_gnt & cpu_misal;
    dma_err_d    = dma_gnt & dma_misal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= 8'd0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dma_rdata_q  <= 32'd0;
      cpu_err_q    <= 1'b0;
      dma_err_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_err_q    <= cpu_err_d;
      dma_err_q    <= dma_err_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_err    = cpu_err_q;
  assign dma_err    = dma_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors push expected responses,
// a negedge monitor pops and compares them when rvalid/err appear.
module tb_dmem_arbiter;

  localparam int NONE = 0;
  localparam int RD   = 1;
  localparam int ER   = 2;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_MemRead, mem_MemWrite;
  logic [31:0] mem_ALUresult, mem_MemWriteData, mem_MemReadData;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  resp_t cpu_q[$];
  resp_t dma_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_gnt          (cpu_gnt),
    .cpu_stall        (cpu_stall),
    .cpu_rvalid       (cpu_rvalid),
    .cpu_rdata        (cpu_rdata),
    .cpu_err          (cpu_err),
    .dma_req          (dma_req),
    .dma_we           (dma_we),
    .dma_addr         (dma_addr),
    .dma_wdata        (dma_wdata),
    .dma_gnt          (dma_gnt),
    .dma_rvalid       (dma_rvalid),
    .dma_rdata        (dma_rdata),
    .dma_err          (dma_err),
    .mem_MemRead      (mem_MemRead),
    .mem_MemWrite     (mem_MemWrite),
    .mem_ALUresult    (mem_ALUresult),
    .mem_MemWriteData (mem_MemWriteData),
    .mem_MemReadData  (mem_MemReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory model: unwritten words read back as 0x1000_0000 + word index.
  bit [31:0] mem_arr [64];
  bit        written [64];
  logic [5:0] mem_idx;
  assign mem_idx = mem_ALUresult[7:2];
  assign mem_MemReadData = written[mem_idx] ? mem_arr[mem_idx] : (32'h1000_0000 + {26'd0, mem_idx});

  always @(posedge clk) begin
    if (mem_MemWrite) begin
      mem_arr[mem_idx] <= mem_MemWriteData;
      written[mem_idx] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational decision, and queues the expected response.
  task automatic applyStimulus(input string tag, input bit rstn,
                               input bit creq, input bit cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                               input bit dreq, input bit dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                               input bit e_cg, input bit e_dg, input bit e_mr, input bit e_mw,
                               input int e_cresp, input logic [31:0] e_cdata,
                               input int e_dresp, input logic [31:0] e_ddata);
    resp_t r;
    @(negedge clk);
    rst_n = rstn;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    #2;
    checkOutput({tag, ".cpu_gnt"},   {31'd0, cpu_gnt},      {31'd0, e_cg});
    checkOutput({tag, ".dma_gnt"},   {31'd0, dma_gnt},      {31'd0, e_dg});
    checkOutput({tag, ".cpu_stall"}, {31'd0, cpu_stall},    {31'd0, creq & ~e_cg});
    checkOutput({tag, ".MemRead"},   {31'd0, mem_MemRead},  {31'd0, e_mr});
    checkOutput({tag, ".MemWrite"},  {31'd0, mem_MemWrite}, {31'd0, e_mw});
    if (e_mr || e_mw) begin
      checkOutput({tag, ".addr"}, mem_ALUresult, e_cg ? caddr : daddr);
    end
    if (e_mw) begin
      checkOutput({tag, ".wdata"}, mem_MemWriteData, e_cg ? cwd : dwd);
    end
    if (!e_cg && !e_dg) begin
      checkOutput({tag, ".idle_addr"},  mem_ALUresult,    32'd0);
      checkOutput({tag, ".idle_wdata"}, mem_MemWriteData, 32'd0);
    end
    if (e_cresp != NONE) begin
      r.is_err = (e_cresp == ER); r.data = e_cdata; r.cyc = cyc + 1;
      cpu_q.push_back(r);
    end
    if (e_dresp != NONE) begin
      r.is_err = (e_dresp == ER); r.data = e_ddata; r.cyc = cyc + 1;
      dma_q.push_back(r);
    end
  endtask

  // Monitor: each response must match the head of its port's queue in the expected cycle.
  always @(negedge clk) begin
    resp_t e;
    while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
      e = cpu_q.pop_front();
      checks++; failures++;
      $display("[TB] FAIL cpu_missing_resp actual=none expected_cycle=%0d data=0x%0h", e.cyc, e.data);
    end
    while (dma_q.size() > 0 && dma_q[0].cyc < cyc) begin
      e = dma_q.pop_front();
      checks++; failures++;
      $display("[TB] FAIL dma_missing_resp actual=none expected_cycle=%0d data=0x%0h", e.cyc, e.data);
    end
    if (cpu_rvalid || cpu_err) begin
      if (cpu_q.size() == 0 || cpu_q[0].cyc != cyc) begin
        checks++; failures++;
        $display("[TB] FAIL cpu_unexpected_resp actual=rvalid:%0b err:%0b expected=none cycle=%0d", cpu_rvalid, cpu_err, cyc);
      end else begin
        e = cpu_q.pop_front();
        checkOutput("cpu_resp.err",    {31'd0, cpu_err},    {31'd0, e.is_err});
        checkOutput("cpu_resp.rvalid", {31'd0, cpu_rvalid}, {31'd0, ~e.is_err});
        if (!e.is_err) checkOutput("cpu_resp.rdata", cpu_rdata, e.data);
      end
    end
    if (dma_rvalid || dma_err) begin
      if (dma_q.size() == 0 || dma_q[0].cyc != cyc) begin
        checks++; failures++;
        $display("[TB] FAIL dma_unexpected_resp actual=rvalid:%0b err:%0b expected=none cycle=%0d", dma_rvalid, dma_err, cyc);
      end else begin
        e = dma_q.pop_front();
        checkOutput("dma_resp.err",    {31'd0, dma_err},    {31'd0, e.is_err});
        checkOutput("dma_resp.rvalid", {31'd0, dma_rvalid}, {31'd0, ~e.is_err});
        if (!e.is_err) checkOutput("dma_resp.rdata", dma_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

    // Requests during reset must not be granted.
    applyStimulus("rst0", 0, 1,1,32'h10,32'h1, 1,0,32'h20,0, 0,0,0,0, NONE,0, NONE,0);
    applyStimulus("rst1", 0, 1,0,32'h10,0,     1,0,32'h20,0, 0,0,0,0, NONE,0, NONE,0);

    applyStimulus("st10", 1, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 1,0,0,1, NONE,0, NONE,0);
    checkOutput("rst.cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    checkOutput("rst.dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    checkOutput("rst.cpu_rdata",  cpu_rdata, 32'd0);
    checkOutput("rst.dma_rdata",  dma_rdata, 32'd0);
    checkOutput("rst.cpu_err",    {31'd0, cpu_err}, 32'd0);
    checkOutput("rst.dma_err",    {31'd0, dma_err}, 32'd0);
    checkOutput("rst.starve_cnt", {24'd0, dut.starve_cnt_q}, 32'd0);

    applyStimulus("ld10", 1, 1,0,32'h10,0, 0,0,0,0, 1,0,1,0, RD,32'hDEADBEEF, NONE,0);
    applyStimulus("idle", 1, 0,0,0,0, 0,0,0,0, 0,0,0,0, NONE,0, NONE,0);

    // Continuous CPU stores against a waiting DMA load: DMA forced in on the fifth cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("starve%0d", i), 1, 1,1,32'h30,32'hC000_00C0 + i, 1,0,32'h50,0,
                    1,0,0,1, NONE,0, NONE,0);
    end
    applyStimulus("starve4", 1, 1,1,32'h30,32'hC000_00C4, 1,0,32'h50,0, 0,1,1,0, NONE,0, RD,32'h1000_0014);
    applyStimulus("starve5", 1, 1,1,32'h30,32'hC000_00C4, 1,0,32'h54,0, 1,0,0,1, NONE,0, NONE,0);
    checkOutput("starve5.starve_cnt", {24'd0, dut.starve_cnt_q}, 32'd0);
    applyStimulus("starve6", 1, 0,0,0,0, 1,0,32'h54,0, 0,1,1,0, NONE,0, RD,32'h1000_0015);
    applyStimulus("ld30",    1, 1,0,32'h30,0, 0,0,0,0, 1,0,1,0, RD,32'hC000_00C4, NONE,0);

    applyStimulus("dst40", 1, 0,0,0,0, 1,1,32'h40,32'h12345678, 0,1,0,1, NONE,0, NONE,0);
    applyStimulus("ld40",  1, 1,0,32'h40,0, 0,0,0,0, 1,0,1,0, RD,32'h12345678, NONE,0);

    // DMA drops its request mid-wait: counter clears, CPU keeps winning afterwards.
    applyStimulus("drop0", 1, 1,1,32'h34,32'h1, 1,0,32'h58,0, 1,0,0,1, NONE,0, NONE,0);
    applyStimulus("drop1", 1, 1,1,32'h34,32'h2, 1,0,32'h58,0, 1,0,0,1, NONE,0, NONE,0);
    checkOutput("drop1.starve_cnt", {24'd0, dut.starve_cnt_q}, 32'd1);
    applyStimulus("drop2", 1, 1,1,32'h34,32'h3, 0,0,0,0, 1,0,0,1, NONE,0, NONE,0);
    applyStimulus("drop3", 1, 1,1,32'h34,32'h4, 1,0,32'h58,0, 1,0,0,1, NONE,0, NONE,0);
    checkOutput("drop3.starve_cnt", {24'd0, dut.starve_cnt_q}, 32'd0);
    applyStimulus("drop4", 1, 0,0,0,0, 1,0,32'h58,0, 0,1,1,0, NONE,0, RD,32'h1000_0016);

    // Misaligned accesses are consumed without touching memory.
    applyStimulus("mis22", 1, 1,1,32'h22,32'hFFFF_FFFF, 0,0,0,0, 1,0,0,0, ER,0, NONE,0);
    applyStimulus("ld20",  1, 1,0,32'h20,0, 0,0,0,0, 1,0,1,0, RD,32'h1000_0008, NONE,0);
    applyStimulus("mis41", 1, 0,0,0,0, 1,0,32'h41,0, 0,1,0,0, NONE,0, ER,0);

    // Reset right after a granted load discards state for the following cycle.
    applyStimulus("ldpre", 1, 1,0,32'h10,0, 0,0,0,0, 1,0,1,0, RD,32'hDEADBEEF, NONE,0);
    applyStimulus("rstm",  0, 1,0,32'h10,0, 1,0,32'h50,0, 0,0,0,0, NONE,0, NONE,0);
    applyStimulus("post",  1, 0,0,0,0, 0,0,0,0, 0,0,0,0, NONE,0, NONE,0);
    checkOutput("post.cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    checkOutput("post.cpu_rdata",  cpu_rdata, 32'd0);
    checkOutput("post.dma_rdata",  dma_rdata, 32'd0);
    checkOutput("post.starve_cnt", {24'd0, dut.starve_cnt_q}, 32'd0);
    applyStimulus("ld40b", 1, 1,0,32'h40,0, 0,0,0,0, 1,0,1,0, RD,32'h12345678, NONE,0);

    applyStimulus("tail0", 1, 0,0,0,0, 0,0,0,0, 0,0,0,0, NONE,0, NONE,0);
    applyStimulus("tail1", 1, 0,0,0,0, 0,0,0,0, 0,0,0,0, NONE,0, NONE,0);
    @(negedge clk);
    #2;
    checkOutput("cpu_q_drained", cpu_q.size(), 32'd0);
    checkOutput("dma_q_drained", dma_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port word-addressed data memory between the pipeline MEM stage (CPU port) and a DMA/loader port. Each cycle it grants at most one requester. It drives the memory's MemRead, MemWrite, address and write-data inputs, and registers read data back to the winning port one cycle later. CPU has fixed priority; a saturating starvation counter forces a DMA grant after a bounded wait. The CPU stall output feeds the pipeline hazard logic.

## Interface
- STARVE_LIMIT, 4, consecutive denied DMA request cycles before DMA gets forced priority; legal range 1..255
- ADDR_W, 32, byte-address width of both requester ports and the memory address output
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  cpu_rdata valid (registered)
- cpu_rdata  out  32  CPU load data (registered)
- cpu_err  out  1  misaligned CPU access, one-cycle pulse (registered)
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err  same directions, widths and meanings as the CPU equivalents, for the DMA port
- mem_MemRead  out  1  to memory read enable
- mem_MemWrite  out  1  to memory write enable; the memory writes at posedge
- mem_ALUresult  out  ADDR_W  to memory byte address; the memory ignores bits [1:0]
- mem_MemWriteData  out  32  to memory write data
- mem_MemReadData  in  32  from memory, combinational read data

## Operation
- Sequential state:
  - starve_cnt: width 8, saturates at STARVE_LIMIT
  - rdata register, rvalid/err registers per port
- dma_pri = (starve_cnt == STARVE_LIMIT).
- Grant rule, evaluated every cycle; at most one grant, never both:
  - dma_req & dma_pri: grant DMA.
  - Otherwise, cpu_req: grant CPU.
  - Otherwise, dma_req: grant DMA.
  - Otherwise: no grant.
- starve_cnt next-state:
  - Cleared when dma_gnt or ~dma_req.
  - Incremented when dma_req & ~dma_gnt & starve_cnt < STARVE_LIMIT.
  - Otherwise held.
- Granted aligned access (addr[1:0]==0):
  - mem_ALUresult, mem_MemWriteData are muxed from the winner.
  - mem_MemRead = ~we; mem_MemWrite = we.
- Granted misaligned access (addr[1:0]!=0):
  - The grant is still issued, so the request is consumed.
  - mem_MemRead = mem_MemWrite = 0; no memory side effect.
  - The winner's err pulses next cycle; rvalid stays 0.
- No grant: mem_MemRead = mem_MemWrite = 0; mem_ALUresult and mem_MemWriteData = 0.
- Granted aligned load:
  - mem_MemReadData is captured into the winner's rdata at posedge.
  - The winner's rvalid pulses for exactly the next cycle.
  - rdata holds its value until the next load to that port.
- Stores produce no rvalid.
- ADDR_W above the memory's depth simply passes through; no range checking is done here.

## Timing
- Reset (rst_n=0 at posedge):
  - starve_cnt=0; cpu_rvalid=dma_rvalid=0; cpu_rdata=dma_rdata=0; cpu_err=dma_err=0.
  - Grants are also forced to 0 while rst_n=0, so no memory access occurs during reset.
- Grant, stall and mem_* outputs are combinational from the request inputs and starve_cnt: zero-cycle decision.
- Store latency: the memory is written at the same posedge the grant is sampled.
- Load latency: 1 cycle. Grant in cycle N gives rvalid/rdata in cycle N+1.
- Back-to-back grants to the same port are allowed every cycle; rvalid may stay high across consecutive loads.
- Simultaneous cpu_req & dma_req with starve_cnt < STARVE_LIMIT: the CPU wins and starve_cnt increments.
- With continuous CPU traffic, DMA is granted at most STARVE_LIMIT+1 cycles after first request.
- The cycle after a forced DMA grant, starve_cnt=0 and the CPU regains priority.
- Reset asserted mid-operation discards any pending rvalid/err and clears starve_cnt; the next access after reset sees no stale response.

## Test plan
- Reset, then CPU store 0xDEADBEEF to 0x10, then CPU load 0x10 -> cpu_gnt=1 both cycles; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF exactly one cycle after the load grant; dma_rvalid=0 throughout.
- cpu_req held high continuously with dma_req high from cycle 0, STARVE_LIMIT=4:
  - Cycles 0-3: cpu_gnt=1, dma_gnt=0.
  - Cycle 4: dma_gnt=1, cpu_stall=1.
  - Cycle 5: cpu_gnt=1 and starve_cnt=0.
- DMA-only store 0x12345678 to 0x40, then CPU load 0x40 -> cpu_rdata=0x12345678. Also dma_req dropped mid-wait resets starve_cnt to 0.
- CPU store to 0x22 (misaligned) -> cpu_gnt=1, mem_MemWrite=0, cpu_err pulse next cycle; a subsequent load of 0x20 returns the prior contents unchanged.
- rst_n low for one cycle directly after a granted load -> cpu_rvalid=0 and cpu_rdata=0 in the following cycle; no grants while rst_n=0.
